// File: rtl/tx_ctrl.sv
// FIFO-to-UART transmit controller: pops one byte per launch, re-issues the
// launch strobe when the transmitter never reports busy, counts completed bytes.
module tx_ctrl #(
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_EMPTY,
  input  logic [7:0]  RD_DATA,
  output logic        RD_INC,
  input  logic        TX_BUSY,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  output logic [15:0] TX_CNT,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned CW = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rd_inc_q, rd_inc_d;
  logic          tdv_q, tdv_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rd_inc_d = 1'b0;
    tdv_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!FIFO_EMPTY && !TX_BUSY) begin
          data_d   = RD_DATA;
          rd_inc_d = 1'b1;
          tdv_d    = 1'b1;
          tmo_d    = '0;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: begin
        // Busy wins over an expiring counter: no retry once the frame started.
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_MAX) begin
          err_d = 1'b1;
          tdv_d = 1'b1;
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tmo_d   = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rd_inc_q <= 1'b0;
      tdv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rd_inc_q <= rd_inc_d;
      tdv_q    <= tdv_d;
      err_q    <= err_d;
    end
  end

  assign RD_INC        = rd_inc_q;
  assign TX_DATA_VALID = tdv_q;
  assign TX_P_DATA     = data_q;
  assign TX_CNT        = cnt_q;
  assign TIMEOUT_ERR   = err_q;

endmodule

// File: tb/tb_tx_ctrl.sv
// Directed bench for tx_ctrl: FIFO and UART transmitter are modelled in the
// stimulus sequence, every expected value is hand-derived.
module tb_tx_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FIFO_EMPTY;
  logic [7:0]  RD_DATA;
  logic        RD_INC;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic [15:0] TX_CNT;
  logic        TIMEOUT_ERR;

  int          checks = 0;
  int          errors = 0;
  int          n_rd, n_tdv, n_err;
  logic [15:0] exp_cnt;
  logic [7:0]  fifo[$];

  tx_ctrl #(.BUSY_TIMEOUT(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .RD_DATA       (RD_DATA),
    .RD_INC        (RD_INC),
    .TX_BUSY       (TX_BUSY),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_CNT        (TX_CNT),
    .TIMEOUT_ERR   (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    FIFO_EMPTY = (fifo.size() == 0);
    RD_DATA    = FIFO_EMPTY ? 8'h00 : fifo[0];
  endtask

  // FIFO pops at the edge where RD_INC is high, like the real read side.
  task automatic tick();
    logic p;
    p = RD_INC;
    @(posedge CLK);
    #1;
    if (p === 1'b1 && fifo.size() > 0) fifo.delete(0);
    upd();
    n_rd  += int'(RD_INC === 1'b1);
    n_tdv += int'(TX_DATA_VALID === 1'b1);
    n_err += int'(TIMEOUT_ERR === 1'b1);
  endtask

  task automatic wait_tdv(input string tag);
    int n;
    n = 0;
    while (TX_DATA_VALID !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(TX_DATA_VALID), 32'd1);
  endtask

  task automatic byte_done(input string tag, input int after, input int len);
    repeat (after) tick();
    TX_BUSY = 1'b1;
    repeat (len) tick();
    TX_BUSY = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_cnt"}, 32'(TX_CNT), 32'(exp_cnt));
    chk({tag, "_idle_gap"}, 32'(TX_DATA_VALID), 32'd0);
  endtask

  initial begin
    logic [7:0] bytes3 [3];
    bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;

    RST = 1'b1; TX_BUSY = 1'b0; upd();
    tick(); tick();
    chk("rst_rd_inc", 32'(RD_INC), 32'd0);
    chk("rst_tdv",    32'(TX_DATA_VALID), 32'd0);
    chk("rst_err",    32'(TIMEOUT_ERR), 32'd0);
    chk("rst_data",   32'(TX_P_DATA), 32'h00);
    chk("rst_cnt",    32'(TX_CNT), 32'h0000);
    RST = 1'b0; exp_cnt = 16'h0000;
    tick();
    chk("idle_empty_no_pop", 32'(RD_INC), 32'd0);

    // Single byte A5
    fifo.push_back(8'hA5); upd();
    n_rd = 0; n_tdv = 0; n_err = 0;
    wait_tdv("t1_launch");
    chk("t1_rd_inc", 32'(RD_INC), 32'd1);
    chk("t1_data",   32'(TX_P_DATA), 32'hA5);
    tick();
    chk("t1_rd_inc_1cyc", 32'(RD_INC), 32'd0);
    chk("t1_tdv_1cyc",    32'(TX_DATA_VALID), 32'd0);
    byte_done("t1", 1, 10);
    tick();
    chk("t1_n_rd",  32'(n_rd), 32'd1);
    chk("t1_n_tdv", 32'(n_tdv), 32'd1);
    chk("t1_data_hold", 32'(TX_P_DATA), 32'hA5);

    // Three bytes back-to-back
    foreach (bytes3[i]) fifo.push_back(bytes3[i]);
    upd();
    n_rd = 0; n_tdv = 0; n_err = 0;
    for (int i = 0; i < 3; i++) begin
      wait_tdv($sformatf("t2_launch%0d", i));
      chk($sformatf("t2_data%0d", i), 32'(TX_P_DATA), 32'(bytes3[i]));
      byte_done($sformatf("t2_b%0d", i), 2, 3);
    end
    tick();
    chk("t2_n_rd",  32'(n_rd), 32'd3);
    chk("t2_n_tdv", 32'(n_tdv), 32'd3);
    chk("t2_fifo_empty", 32'(fifo.size()), 32'd0);

    // Timeout retry: transmitter ignores the first strobe
    fifo.push_back(8'h5A); upd();
    n_rd = 0; n_tdv = 0; n_err = 0;
    wait_tdv("t3_launch");
    repeat (4) tick();
    chk("t3_no_err_early", 32'(n_err), 32'd0);
    tick();
    chk("t3_err",       32'(TIMEOUT_ERR), 32'd1);
    chk("t3_retry_tdv", 32'(TX_DATA_VALID), 32'd1);
    chk("t3_retry_rd",  32'(RD_INC), 32'd0);
    chk("t3_data",      32'(TX_P_DATA), 32'h5A);
    byte_done("t3", 1, 3);
    chk("t3_n_rd",  32'(n_rd), 32'd1);
    chk("t3_n_tdv", 32'(n_tdv), 32'd2);
    chk("t3_n_err", 32'(n_err), 32'd1);

    // Busy arrives exactly on the expiry cycle: no retry
    fifo.push_back(8'h6B); upd();
    n_rd = 0; n_tdv = 0; n_err = 0;
    wait_tdv("t3b_launch");
    repeat (4) tick();
    TX_BUSY = 1'b1;
    tick();
    chk("t3b_no_err", 32'(TIMEOUT_ERR), 32'd0);
    chk("t3b_no_tdv", 32'(TX_DATA_VALID), 32'd0);
    byte_done("t3b", 0, 2);
    chk("t3b_n_tdv", 32'(n_tdv), 32'd1);
    chk("t3b_n_err", 32'(n_err), 32'd0);

    // Busy held in IDLE blocks the launch
    TX_BUSY = 1'b1;
    fifo.push_back(8'h7C); upd();
    n_rd = 0; n_tdv = 0; n_err = 0;
    repeat (3) tick();
    chk("t4_blocked_rd",  32'(n_rd), 32'd0);
    chk("t4_blocked_tdv", 32'(n_tdv), 32'd0);
    TX_BUSY = 1'b0;
    tick();
    chk("t4_launch_tdv", 32'(TX_DATA_VALID), 32'd1);
    chk("t4_launch_rd",  32'(RD_INC), 32'd1);
    chk("t4_data",       32'(TX_P_DATA), 32'h7C);
    byte_done("t4", 2, 4);

    // Reset during WAIT_DONE
    fifo.push_back(8'h81); fifo.push_back(8'h82); upd();
    wait_tdv("t5_launch");
    tick();
    TX_BUSY = 1'b1;
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("t5_rd_inc", 32'(RD_INC), 32'd0);
    chk("t5_tdv",    32'(TX_DATA_VALID), 32'd0);
    chk("t5_err",    32'(TIMEOUT_ERR), 32'd0);
    chk("t5_data",   32'(TX_P_DATA), 32'h00);
    chk("t5_cnt",    32'(TX_CNT), 32'h0000);
    chk("t5_fifo_words", 32'(fifo.size()), 32'd1);
    RST = 1'b0; TX_BUSY = 1'b0;
    fifo.delete(); upd();
    exp_cnt = 16'h0000;
    n_rd = 0; n_tdv = 0;
    repeat (3) tick();
    chk("t5_no_repop", 32'(n_rd), 32'd0);
    chk("t5_no_retry", 32'(n_tdv), 32'd0);
    chk("t5_cnt_hold", 32'(TX_CNT), 32'h0000);

    // Counter wrap
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    fifo.push_back(8'h90); upd();
    wait_tdv("t6_launch");
    byte_done("t6_wrap", 2, 3);
    chk("t6_cnt_zero", 32'(TX_CNT), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_ctrl.md
TX_CTRL -- requirements
Module: tx_ctrl

Interface
REQ-001 Parameter: BUSY_TIMEOUT, default 255, max cycles in WAIT_START without TX_BUSY=1 before the byte is re-issued.
REQ-002 CLK  input  1  single clock; all logic rising-edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 FIFO_EMPTY  input  1  FIFO read-side empty flag, synchronous to CLK.
REQ-005 RD_DATA  input  8  FIFO head word, first-word-fall-through, valid while FIFO_EMPTY=0.
REQ-006 RD_INC  output  1  one-cycle pop strobe to the FIFO read side.
REQ-007 TX_BUSY  input  1  UART transmitter busy, high from frame start to stop bit.
REQ-008 TX_P_DATA  output  8  byte presented to the UART transmitter.
REQ-009 TX_DATA_VALID  output  1  one-cycle launch strobe to the UART transmitter.
REQ-010 TX_CNT  output  16  count of completed bytes.
REQ-011 TIMEOUT_ERR  output  1  one-cycle pulse per BUSY_TIMEOUT expiry.

Function
REQ-012 States SHALL be exactly IDLE, WAIT_START, WAIT_DONE; all outputs SHALL be registered.
REQ-013 IDLE: if FIFO_EMPTY=0 and TX_BUSY=0 at an edge, then at that edge TX_P_DATA<=RD_DATA, RD_INC<=1, TX_DATA_VALID<=1, timeout counter<=0, state<=WAIT_START.
REQ-014 IDLE with FIFO_EMPTY=1 or TX_BUSY=1 SHALL hold state with no strobes and no pop.
REQ-015 RD_INC SHALL be high for exactly one cycle per launched byte, and SHALL never be high for a retry.
REQ-016 TX_DATA_VALID SHALL be high for exactly one cycle per launch or retry; TX_P_DATA SHALL hold stable from launch until the next launch.
REQ-017 WAIT_START: TX_BUSY=1 -> WAIT_DONE; otherwise the timeout counter increments by 1 per cycle.
REQ-018 WAIT_START, counter = BUSY_TIMEOUT and TX_BUSY=0: TIMEOUT_ERR=1 and TX_DATA_VALID=1 for one cycle, same TX_P_DATA, counter<=0, stay in WAIT_START.
REQ-019 TX_BUSY=1 in the same cycle as the counter expiry: WAIT_DONE takes priority, with no retry and no TIMEOUT_ERR.
REQ-020 WAIT_DONE: TX_BUSY=0 -> TX_CNT<=TX_CNT+1, state<=IDLE; otherwise hold.
REQ-021 TX_CNT SHALL wrap from 16'hFFFF to 16'h0000 silently.
REQ-022 Minimum spacing: next launch no earlier than the cycle after WAIT_DONE exits (one IDLE cycle between bytes).
REQ-023 FIFO_EMPTY or RD_DATA changes while in WAIT_START/WAIT_DONE SHALL have no effect.
REQ-024 An unreachable state encoding SHALL return to IDLE on the next edge with outputs cleared.

Reset
REQ-025 RST=1 at an edge: state=IDLE, RD_INC=0, TX_DATA_VALID=0, TIMEOUT_ERR=0, TX_P_DATA=8'h00, TX_CNT=16'h0000, timeout counter=0.
REQ-026 Reset mid-byte SHALL abandon the byte in flight without a re-pop or retry; TX_CNT is not incremented.
REQ-027 RST has priority over every transition and strobe in the same cycle.

Verification
REQ-028 FIFO holds 8'hA5; TX model asserts TX_BUSY 2 cycles after launch for 10 cycles -> one RD_INC pulse, one TX_DATA_VALID pulse with TX_P_DATA=8'hA5, TX_CNT=1, then IDLE.
REQ-029 FIFO holds 8'h11,8'h22,8'h33 back-to-back -> three launches in order, each with TX_BUSY=0 in the preceding cycle, exactly three RD_INC pulses, TX_CNT=3.
REQ-030 BUSY_TIMEOUT=4 and TX model ignores the first strobe -> TIMEOUT_ERR pulse 5 cycles after launch, second TX_DATA_VALID with the same byte, no second RD_INC; the byte completes and TX_CNT=1.
REQ-031 TX_BUSY held 1 while FIFO_EMPTY=0 in IDLE -> no RD_INC and no TX_DATA_VALID until TX_BUSY=0, then launch on the next edge.
REQ-032 RST=1 asserted in WAIT_DONE -> next cycle all outputs at reset values; FIFO word count unchanged since launch.
REQ-033 TX_CNT preloaded to 16'hFFFF via 65535 transfers (or force) and one more byte -> TX_CNT=16'h0000.
